mem_ctrl: RTL

Synchronous 16 x 8 single-port memory block that the testbench driver's clocking block writes and reads, and whose read data the monitor's clocking block samples. After reset it clears its own storage with an internal init sweep and reports busy until the sweep completes. Reads return registered data with a valid strobe. Requests that arrive while busy are dropped and counted, so the scoreboard can tell rejected traffic from lost data.

---
 rtl/mem_ctrl_if.sv | 34 +++
 rtl/mem_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_if
//  Description : Request/response bundle for the mem_ctrl memory block.
//                master drives addr/wr_en/rd_en/wdata and observes
//                rdata/rd_valid/busy/drop_cnt; slave is the memory side.
//  Ports       : addr, wr_en, rd_en, wdata   (master -> slave)
//                rdata, rd_valid, busy, drop_cnt (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rd_valid;
    logic                  busy;
    logic [7:0]            drop_cnt;

    modport master (
        output addr, wr_en, rd_en, wdata,
        input  rdata, rd_valid, busy, drop_cnt
    );

    modport slave (
        input  addr, wr_en, rd_en, wdata,
        output rdata, rd_valid, busy, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Synchronous DEPTH x DATA_WIDTH single-port memory. After
//                reset an internal sweep writes INIT_VALUE to every entry
//                while busy is high. Reads are registered (1-cycle latency)
//                with a rd_valid pulse and read-before-write ordering.
//                Requests arriving during the sweep are dropped and counted.
//  Ports       : clk    - clock, all state updates on posedge
//                reset  - synchronous active-low reset
//                bus    - mem_ctrl_if.slave (addr, wr_en, rd_en, wdata,
//                         rdata, rd_valid, busy, drop_cnt)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl #(
    parameter int                  ADDR_WIDTH = 4,
    parameter int                  DATA_WIDTH = 8,
    parameter int                  DEPTH      = 16,   // must be 2**ADDR_WIDTH
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_ctrl_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_last_ptr = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rd_valid;
    logic                  r_busy;
    logic [7:0]            r_drop_cnt;

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_rd_fire;
    logic                  w_drop;
    logic                  w_sweep_last;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath controls. The sweep owns the write port in
    // INIT; user traffic owns it in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_mem_we     = 1'b0;
        w_mem_waddr  = bus.addr;
        w_mem_wdata  = bus.wdata;
        w_rd_fire    = 1'b0;
        w_drop       = 1'b0;
        w_sweep_last = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_mem_we     = 1'b1;
                w_mem_waddr  = r_init_ptr;
                w_mem_wdata  = INIT_VALUE;
                w_drop       = bus.wr_en | bus.rd_en;
                w_sweep_last = (r_init_ptr == c_last_ptr);
                if (w_sweep_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_mem_we  = bus.wr_en;
                w_rd_fire = bus.rd_en;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage. Reset deliberately leaves contents alone; the sweep
    // clears them once reset is released.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset && w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Sweep pointer, read port, busy flag and drop counter. The read uses
    // the pre-edge array contents, giving read-before-write on a
    // same-address simultaneous access.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_init_ptr <= '0;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b1;
            r_drop_cnt <= 8'h00;
        end else begin
            if (r_state == ST_INIT) begin
                // Wraps to 0 on the final sweep write.
                r_init_ptr <= r_init_ptr + 1'b1;
            end
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rdata <= r_mem[bus.addr];
            end
            if (w_sweep_last) begin
                r_busy <= 1'b0;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'h01;
            end
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.rd_valid = r_rd_valid;
    assign bus.busy     = r_busy;
    assign bus.drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
